// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
`timescale 1ns/1ps
package wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Register file length-select encodings
    localparam logic [1:0] LEN_WORD = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_BYTE = 2'd2;

    // Result chosen by the arbiter for the write port
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              err;
    } wb_req_t;

endpackage

// File: rtl/load_extend.sv
// Byte/half/word selection and sign/zero extension of raw load data.
`timescale 1ns/1ps
module load_extend
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o,
    output logic            illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection; halves use only the upper address bit so misaligned halves still pick a lane
    always_comb begin
        byte_sel = 8'(rdata_i >> {addr_lo_i, 3'b000});
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension and error classification by load type
    always_comb begin
        data_o     = rdata_i;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        case (funct3_i)
            LB: begin
                data_o = {{24{byte_sel[7]}}, byte_sel};
            end
            LBU: begin
                data_o = {24'h0, byte_sel};
            end
            LH: begin
                data_o     = {{16{half_sel[15]}}, half_sel};
                misalign_o = addr_lo_i[0];
            end
            LHU: begin
                data_o     = {16'h0, half_sel};
                misalign_o = addr_lo_i[0];
            end
            LW: begin
                data_o     = rdata_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: begin
                data_o    = rdata_i;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback controller: ALU/LSU arbitration, register file write port and busy scoreboard.
`timescale 1ns/1ps
module regfile_writeback
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] query_rs1,
    input  logic [REG_AW-1:0] query_rs2,
    output logic              stall,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_rdata,
    input  logic [1:0]        lsu_addr_lo,
    input  logic [2:0]        lsu_funct3,
    output logic              wr_en,
    output logic [REG_AW-1:0] write_address,
    output logic [XLEN-1:0]   write_data,
    output logic [1:0]        reg_data_length,
    output logic              load_err,
    output logic [NREGS-1:0]  busy
);

    logic [XLEN-1:0]   ld_data;
    logic              ld_misalign;
    logic              ld_illegal;

    wb_req_t           req;
    logic              req_valid;

    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] write_address_q, write_address_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic              load_err_q, load_err_d;
    logic [NREGS-1:0]  busy_q, busy_d;

    load_extend u_load_extend (
        .rdata_i    (lsu_rdata),
        .addr_lo_i  (lsu_addr_lo),
        .funct3_i   (lsu_funct3),
        .data_o     (ld_data),
        .misalign_o (ld_misalign),
        .illegal_o  (ld_illegal)
    );

    // Fixed-priority arbiter: the LSU always wins, the ALU waits while a load is offered
    always_comb begin
        lsu_ready = 1'b1;
        alu_ready = !lsu_valid;
        req_valid = lsu_valid | alu_valid;
        req.rd    = alu_rd;
        req.data  = alu_data;
        req.err   = 1'b0;
        if (lsu_valid) begin
            req.rd   = lsu_rd;
            req.data = ld_data;
            req.err  = ld_misalign | ld_illegal;
        end
    end

    // Write port next state; results aimed at x0 are consumed without a write
    always_comb begin
        wr_en_d         = req_valid && (req.rd != '0);
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        load_err_d      = req_valid && req.err;
        if (wr_en_d) begin
            write_address_d = req.rd;
            write_data_d    = req.data;
        end
    end

    // Scoreboard next state; a new issue overrides a retiring write to the same register
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[write_address_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output register for the register file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q         <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            load_err_q      <= 1'b0;
        end else begin
            wr_en_q         <= wr_en_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            load_err_q      <= load_err_d;
        end
    end

    // Busy scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // The register file cannot serve reads in a write cycle, so a pending write also stalls issue
    assign stall = busy_q[query_rs1] | busy_q[query_rs2] | wr_en_q;

    assign wr_en           = wr_en_q;
    assign write_address   = write_address_q;
    assign write_data      = write_data_q;
    assign load_err        = load_err_q;
    assign busy            = busy_q;
    assign reg_data_length = LEN_WORD;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed cases plus randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  query_rs1 = '0;
    logic [4:0]  query_rs2 = '0;
    logic        stall;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_rdata = '0;
    logic [1:0]  lsu_addr_lo = '0;
    logic [2:0]  lsu_funct3 = '0;
    logic        wr_en;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [1:0]  reg_data_length;
    logic        load_err;
    logic [31:0] busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_wr_en = 1'b0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;
    logic        m_err   = 1'b0;
    logic [31:0] m_busy  = '0;

    regfile_writeback dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .query_rs1       (query_rs1),
        .query_rs2       (query_rs2),
        .stall           (stall),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_rd          (lsu_rd),
        .lsu_rdata       (lsu_rdata),
        .lsu_addr_lo     (lsu_addr_lo),
        .lsu_funct3      (lsu_funct3),
        .wr_en           (wr_en),
        .write_address   (write_address),
        .write_data      (write_data),
        .reg_data_length (reg_data_length),
        .load_err        (load_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got 0x%08h want 0x%08h", name, $time, act, exp);
        end
    endtask

    // Load result from the ISA rules: access size, natural alignment, shift and extend
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] a,
                                             input logic [2:0] f3, output logic err);
        int          size;
        int          base;
        int          bits;
        logic [31:0] v;
        logic [31:0] mask;
        if (f3[1:0] == 2'd3 || f3 == 3'b110) begin
            err = 1'b1;
            return word;
        end
        size = 1 << f3[1:0];
        err  = (int'(a) % size) != 0;
        base = int'(a) - (int'(a) % size);
        v    = word >> (8 * base);
        if (size == 4) return v;
        bits = 8 * size;
        mask = (32'h1 << bits) - 32'h1;
        v    = v & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // Model update at each clock edge from the inputs presented in that cycle
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] nb;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        e;
        logic        acc;
        if (!rst_n) begin
            m_wr_en = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_err   = 1'b0;
            m_busy  = '0;
        end else begin
            nb = m_busy;
            if (m_wr_en) nb[m_addr] = 1'b0;
            if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
            m_busy = nb;
            acc = 1'b0;
            e   = 1'b0;
            rd  = '0;
            val = '0;
            if (lsu_valid) begin
                acc = 1'b1;
                rd  = lsu_rd;
                val = ref_load(lsu_rdata, lsu_addr_lo, lsu_funct3, e);
            end else if (alu_valid) begin
                acc = 1'b1;
                rd  = alu_rd;
                val = alu_data;
            end
            m_wr_en = acc && (rd != 0);
            if (m_wr_en) begin
                m_addr = rd;
                m_data = val;
            end
            m_err = acc && lsu_valid && e;
        end
    end

    // Compare all outputs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("wr_en", 32'(wr_en), 32'(m_wr_en));
        if (m_wr_en) begin
            chk("write_address", 32'(write_address), 32'(m_addr));
            chk("write_data", write_data, m_data);
        end
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("reg_data_length", 32'(reg_data_length), 32'd0);
        chk("busy", busy, m_busy);
        chk("lsu_ready", 32'(lsu_ready), 32'd1);
        chk("alu_ready", 32'(alu_ready), 32'(!lsu_valid));
        chk("stall", 32'(stall), 32'(m_busy[query_rs1] | m_busy[query_rs2] | m_wr_en));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
    endtask

    task automatic lsu_one(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                           input logic [31:0] word, input logic [31:0] exp,
                           input logic experr, input string name);
        lsu_valid   = 1'b1;
        lsu_rd      = rd;
        lsu_funct3  = f3;
        lsu_addr_lo = a;
        lsu_rdata   = word;
        tick();
        lsu_valid = 1'b0;
        chk({name, "_wr_en"}, 32'(wr_en), 32'd1);
        chk({name, "_data"}, write_data, exp);
        chk({name, "_err"}, 32'(load_err), 32'(experr));
        tick();
        chk({name, "_err_pulse"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        logic alu_hold;
        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr", 32'(write_address), 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_busy", busy, 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU alone
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 chk("alu_ready_same_cycle", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("alu_wr_en", 32'(wr_en), 32'd1);
        chk("alu_addr", 32'(write_address), 32'd5);
        chk("alu_data", write_data, 32'hDEADBEEF);
        chk("alu_len", 32'(reg_data_length), 32'd0);
        tick();
        chk("alu_wr_en_one_cycle", 32'(wr_en), 32'd0);

        // Collision: LSU first, ALU one cycle later
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0; lsu_rdata = 32'h11112222;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44443333;
        #1 chk("coll_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        lsu_valid = 1'b0;
        chk("coll_lsu_addr", 32'(write_address), 32'd3);
        chk("coll_lsu_data", write_data, 32'h11112222);
        #1 chk("coll_alu_ready_after", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("coll_alu_wr_en", 32'(wr_en), 32'd1);
        chk("coll_alu_addr", 32'(write_address), 32'd4);
        chk("coll_alu_data", write_data, 32'h44443333);
        tick();

        // Extension and error cases
        lsu_one(5'd1, 3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F, 1'b0, "lb_a1");
        lsu_one(5'd2, 3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80, 1'b0, "lb_a3");
        lsu_one(5'd3, 3'b101, 2'd2, 32'h80FF7F01, 32'h000080FF, 1'b0, "lhu_a2");
        lsu_one(5'd4, 3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF, 1'b0, "lh_a2");
        lsu_one(5'd5, 3'b100, 2'd0, 32'h80FF7F81, 32'h00000081, 1'b0, "lbu_a0");
        lsu_one(5'd6, 3'b001, 2'd1, 32'h80FF7F01, 32'h00007F01, 1'b1, "lh_mis");
        lsu_one(5'd7, 3'b010, 2'd2, 32'h80FF7F01, 32'h80FF7F01, 1'b1, "lw_mis");
        lsu_one(5'd8, 3'b111, 2'd0, 32'h80FF7F01, 32'h80FF7F01, 1'b1, "illegal");

        // Scoreboard
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; query_rs1 = 5'd7; query_rs2 = 5'd0;
        #1 chk("sb_stall_busy", 32'(stall), 32'd1);
        chk("sb_busy7", 32'(busy[7]), 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h00000077;
        tick();
        alu_valid = 1'b0;
        chk("sb_stall_wr_cycle", 32'(stall), 32'd1);
        tick();
        chk("sb_stall_drop", 32'(stall), 32'd0);
        chk("sb_busy7_clear", 32'(busy[7]), 32'd0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("sb_reissue_busy7", 32'(busy[7]), 32'd1);
        chk("sb_reissue_stall", 32'(stall), 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd7;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("sb_final_clear", 32'(busy[7]), 32'd0);

        // x0 writes and issues
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1 chk("x0_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        chk("x0_wr_en", 32'(wr_en), 32'd0);
        chk("x0_busy0", 32'(busy[0]), 32'd0);

        // Reset mid-burst
        issue_valid = 1'b1; issue_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA5A5A5A5;
        tick();
        alu_rd = 5'd11;
        tick();
        chk("burst_wr_en", 32'(wr_en), 32'd1);
        chk("burst_busy9", 32'(busy[9]), 32'd1);
        #1 rst_n = 1'b0;
        idle();
        #1 chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
        chk("rst_mid_busy", busy, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);
        tick();
        chk("post_rst_wr_en2", 32'(wr_en), 32'd0);

        // Randomized traffic checked by the model each cycle
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(299) == 0) rst_n = 1'b0;
            alu_hold    = alu_valid && lsu_valid;
            issue_valid = ($urandom_range(2) == 0);
            issue_rd    = 5'($urandom_range(7));
            query_rs1   = 5'($urandom_range(7));
            query_rs2   = 5'($urandom_range(31));
            lsu_valid   = ($urandom_range(2) == 0);
            lsu_rd      = 5'($urandom_range(7));
            lsu_rdata   = $urandom;
            lsu_addr_lo = 2'($urandom_range(3));
            lsu_funct3  = 3'($urandom_range(7));
            if (!alu_hold) begin
                alu_valid = ($urandom_range(1) == 0);
                alu_rd    = 5'($urandom_range(7));
                alu_data  = $urandom;
            end
        end
        idle();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
